vc_dest_arbiter: RTL
====================

Name: vc_dest_arbiter

Overview:
Controller for the TX virtual-channel stage. Arbitrates pops from the VC0 and VC1 FIFOs (16-deep) and routes each popped word by its destination bit into the D0 or D1 FIFO (4-deep). It honours the destination pause flags and the FSM active state. It reports delivered-word counts, an idle flag and a sticky error flag.

Parameters:
DATA_WIDTH, 6, width of a data word
DEST_BIT, 4, bit index selecting the destination (0 = D0, 1 = D1)
CNT_WIDTH, 8, width of the delivered-word counters

Ports:
clk  in  1  system clock, all logic on the rising edge
RESET  in  1  synchronous, active-high reset
ACTIVE  in  1  FSM active state; pops are allowed only while high
VC0_EMPTY, VC1_EMPTY  in  1  VC FIFO empty flags
VC0_VALID, VC1_VALID  in  1  VC FIFO read-data valid, one cycle after a pop
DATA_OUT_VC0, DATA_OUT_VC1  in  DATA_WIDTH  VC FIFO read data
D0_PAUSE, D1_PAUSE  in  1  destination almost-full flags
D0_FULL, D1_FULL  in  1  destination full flags
POP_VC0, POP_VC1  out  1  combinational pop strobes, at most one high per cycle
PUSH_D0, PUSH_D1  out  1  registered push strobes
DATA_TO_D0, DATA_TO_D1  out  DATA_WIDTH  registered push data
D0_COUNT, D1_COUNT  out  CNT_WIDTH  words pushed per destination
ARB_IDLE  out  1  high in state IDLE
ARB_ERR  out  1  sticky error flag

Behaviour:
- Reset (RESET high at a clock edge): state = IDLE; pend = 0; last_grant = VC1; all outputs 0. POP_* is forced to 0 while RESET is high.
- Pop condition: pop_ok = (state == RUN) & ACTIVE & ~D0_PAUSE & ~D1_PAUSE.
- Grant, strict priority:
  - If pop_ok & ~VC0_EMPTY: POP_VC0 = 1.
  - Else if pop_ok & ~VC1_EMPTY: POP_VC1 = 1.
  - Each pop sets pend = 1 and pend_src = the popped VC at the next edge. It also updates last_grant.
  - Back-to-back pops are allowed, one per cycle.
- Receive, in the cycle after a pop (pend = 1):
  - The block expects VALID from pend_src.
  - If that VALID is high: word w = DATA_OUT of pend_src. If w[DEST_BIT] = 0, the target is D0, else D1.
  - If the target FULL is low: at the next edge PUSH_Dx = 1, DATA_TO_Dx = w, and Dx_COUNT increments (wraps modulo 2^CNT_WIDTH).
  - If the target FULL is high: the word is dropped, there is no push, and ARB_ERR is set.
  - If pend = 1 but the expected VALID is low: ARB_ERR is set.
  - VALID from the non-pending VC is ignored.
  - pend clears unless a new pop occurs in the same cycle.
- Non-selected DATA_TO_Dx holds its last value. PUSH_Dx is 1 for one cycle per word.
- Latency: pop at cycle N, VALID at N+1, PUSH at N+2. At most 2 words are in flight, so destination pause thresholds must leave 2 free entries.
- FSM:
  - IDLE -> RUN when ACTIVE & ~(VC0_EMPTY & VC1_EMPTY).
  - RUN -> DRAIN when ~ACTIVE, or when both VC FIFOs are empty and no pop occurs this cycle.
  - RUN stays in RUN while paused; no pops are issued.
  - DRAIN: no pops; -> IDLE when pend = 0.
  - DRAIN -> RUN directly if ACTIVE & a VC is non-empty & pend = 0.
- ARB_ERR clears only on RESET.
- RESET mid-transfer discards the in-flight word: no push, no count.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: when both VC FIFOs are non-empty and pop_ok is high, the grant goes to the VC opposite last_grant. Reset last_grant = VC1, so VC0 is served first. A single non-empty VC is always granted.
- Undefined: strict VC0 priority as above; last_grant has no effect.

Test Plan:
- RESET 2 cycles, ACTIVE=1, VC0 holds 0x05 (dest bit 0) -> POP_VC0 at N, PUSH_D0=1 with DATA_TO_D0=0x05 at N+2, D0_COUNT=1, ARB_IDLE returns 1.
- VC1 holds 0x35, 0x22 -> PUSH_D1 (0x35) then PUSH_D0 (0x22) on consecutive cycles; D1_COUNT=1, D0_COUNT=1.
- Both VCs hold 3 words each:
  - Without the macro: 3 VC0 pops, then 3 VC1 pops.
  - With ARB_ROUND_ROBIN_EN: pops alternate VC0, VC1, VC0, ...
- D1_PAUSE=1 while VCs are non-empty -> no POP_* and state stays RUN; release -> pops resume next cycle.
- Routed word hits D0_FULL=1 in its routing cycle -> no PUSH_D0, ARB_ERR=1 and stays 1 until RESET.
- ACTIVE drops with one word in flight -> that word is still pushed, state goes DRAIN -> IDLE, no further pops; RESET during pend -> no push, counts 0.

Source files
------------

// File: rtl/vc_dest_arbiter.sv
// vc_dest_arbiter: TX virtual-channel stage controller.
// Pops the VC0/VC1 FIFOs (one word per cycle at most) and routes each popped
// word to the D0 or D1 FIFO according to bit DEST_BIT of the word.
// Pop -> VALID -> PUSH takes two cycles, so at most two words are in flight.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate the grant between
// VC0 and VC1 while both hold data; otherwise VC0 has strict priority.
module vc_dest_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  RESET,
    input  logic                  ACTIVE,
    input  logic                  VC0_EMPTY,
    input  logic                  VC1_EMPTY,
    input  logic                  VC0_VALID,
    input  logic                  VC1_VALID,
    input  logic [DATA_WIDTH-1:0] DATA_OUT_VC0,
    input  logic [DATA_WIDTH-1:0] DATA_OUT_VC1,
    input  logic                  D0_PAUSE,
    input  logic                  D1_PAUSE,
    input  logic                  D0_FULL,
    input  logic                  D1_FULL,
    output logic                  POP_VC0,
    output logic                  POP_VC1,
    output logic                  PUSH_D0,
    output logic                  PUSH_D1,
    output logic [DATA_WIDTH-1:0] DATA_TO_D0,
    output logic [DATA_WIDTH-1:0] DATA_TO_D1,
    output logic [CNT_WIDTH-1:0]  D0_COUNT,
    output logic [CNT_WIDTH-1:0]  D1_COUNT,
    output logic                  ARB_IDLE,
    output logic                  ARB_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    pend;        // a word was popped last cycle
    logic                    pend_src;    // 0 = VC0, 1 = VC1
    logic                    pop_ok;
    logic                    pop_any;
    logic                    any_data;
    logic                    rx_valid;
    logic                    rx_dest;
    logic [DATA_WIDTH-1:0]   rx_word;
    logic                    push0_next;
    logic                    push1_next;
    logic                    err_next;
`ifdef ARB_ROUND_ROBIN_EN
    logic                    last_grant;  // 0 = VC0, 1 = VC1
`endif

    // Pops are gated by RESET so nothing leaves a VC FIFO while in reset.
    assign pop_ok   = (state == ST_RUN) & ACTIVE & ~D0_PAUSE & ~D1_PAUSE & ~RESET;
    assign pop_any  = POP_VC0 | POP_VC1;
    assign any_data = ~(VC0_EMPTY & VC1_EMPTY);

    // Grant selection: at most one pop strobe per cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        POP_VC0 = 1'b0;
        POP_VC1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (pop_ok && !VC0_EMPTY && !VC1_EMPTY) begin
            POP_VC0 = last_grant;
            POP_VC1 = ~last_grant;
        end else if (pop_ok && !VC0_EMPTY) begin
            POP_VC0 = 1'b1;
        end else if (pop_ok && !VC1_EMPTY) begin
            POP_VC1 = 1'b1;
        end
`else
        if (pop_ok && !VC0_EMPTY) begin
            POP_VC0 = 1'b1;
        end else if (pop_ok && !VC1_EMPTY) begin
            POP_VC1 = 1'b1;
        end
`endif
    end

    // Receive path: decode the word returned by the pending VC and pick its destination.
    always_comb begin
        rx_valid   = pend & (pend_src ? VC1_VALID : VC0_VALID);
        rx_word    = pend_src ? DATA_OUT_VC1 : DATA_OUT_VC0;
        rx_dest    = rx_word[DEST_BIT];
        push0_next = rx_valid & ~rx_dest & ~D0_FULL;
        push1_next = rx_valid &  rx_dest & ~D1_FULL;
        // Missing VALID or a full target both count as errors; the word is lost.
        err_next   = (pend & ~rx_valid) | (rx_valid & (rx_dest ? D1_FULL : D0_FULL));
    end

    // Next-state logic for the IDLE / RUN / DRAIN controller.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (ACTIVE && any_data) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!ACTIVE || (!any_data && !pop_any)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!pend) state_next = (ACTIVE && any_data) ? ST_RUN : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, in-flight tracking, push outputs, counters and flags.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RESET) begin
            state      <= ST_IDLE;
            pend       <= 1'b0;
            pend_src   <= 1'b0;
            PUSH_D0    <= 1'b0;
            PUSH_D1    <= 1'b0;
            DATA_TO_D0 <= '0;
            DATA_TO_D1 <= '0;
            D0_COUNT   <= '0;
            D1_COUNT   <= '0;
            ARB_IDLE   <= 1'b0;
            ARB_ERR    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state    <= state_next;
            pend     <= pop_any;
            pend_src <= POP_VC1;
            PUSH_D0  <= push0_next;
            PUSH_D1  <= push1_next;
            if (push0_next) begin
                DATA_TO_D0 <= rx_word;
                D0_COUNT   <= D0_COUNT + CNT_WIDTH'(1);
            end
            if (push1_next) begin
                DATA_TO_D1 <= rx_word;
                D1_COUNT   <= D1_COUNT + CNT_WIDTH'(1);
            end
            if (err_next) ARB_ERR <= 1'b1;
            ARB_IDLE <= (state_next == ST_IDLE);
`ifdef ARB_ROUND_ROBIN_EN
            if (pop_any) last_grant <= POP_VC1;
`endif
        end
    end

endmodule
